// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 frame layout constants and parity helper.
//   PS2_FRAME_BITS / *_IDX : bit positions within an 11-bit PS/2 frame
//   odd_parity_ok          : 1 when data plus parity bit hold an odd number of ones
package ps2_pkg;
   localparam int PS2_FRAME_BITS = 11;
   localparam int PS2_START_IDX  = 0;
   localparam int PS2_PARITY_IDX = 9;
   localparam int PS2_STOP_IDX   = 10;
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
      return ^{data, parity};
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: byte-wide show-ahead FIFO with wrap-bit pointers.
//   clk, rst (sync, active-low) ; push/din write ; pop read
//   head  : oldest byte, 0x00 when empty
//   full, empty : occupancy flags
module sync_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] head,
   output logic       full,
   output logic       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = 1;
   logic [AW:0] wptr, rptr;
   logic [7:0]  mem [DEPTH];
   logic        do_push, do_pop;
   assign empty   = wptr == rptr;
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   // a push into a full FIFO is accepted when a pop frees the head slot in the same cycle
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign head    = empty ? 8'h00 : mem[rptr[AW-1:0]];
   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + ONE;
         if (do_pop)  rptr <= rptr + ONE;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 receiver that deframes 11-bit frames into a byte FIFO.
//   clk, rst (sync, active-low)
//   ps2_clk, ps2_data : asynchronous PS/2 pair
//   rd_en     : pop head byte (ignored while empty)
//   data_out  : head byte, 0x00 when empty ; valid : FIFO non-empty
//   overflow  : sticky, good frame dropped on full FIFO
//   frame_err : one-cycle pulse on start/stop/parity failure
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT    = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       rd_en,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       overflow,
   output logic       frame_err
);
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [2:0]              s;
   logic [1:0]              d;
   logic [3:0]              cnt;
   logic [PS2_STOP_IDX-1:0] shift;
   logic [TW-1:0]           tcnt;
   logic                    e, last, good, push, full, empty;
   assign e     = s[2] & ~s[1];
   assign last  = e && cnt == 4'(PS2_STOP_IDX);
   // the stop bit is never stored: it is checked straight from the synchroniser
   assign good  = ~shift[PS2_START_IDX] & d[1] & odd_parity_ok(shift[8:1], shift[PS2_PARITY_IDX]);
   assign push  = last && good;
   assign valid = !empty;
   always_ff @(posedge clk) begin
      if (!rst) begin
         s         <= '1;
         d         <= '1;
         cnt       <= '0;
         shift     <= '0;
         tcnt      <= '0;
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         s         <= {s[1:0], ps2_clk};
         d         <= {d[0], ps2_data};
         frame_err <= last && !good;
         if (push && full && !rd_en) overflow <= 1'b1;
         if (e) begin
            if (!last) shift[cnt] <= d[1];
            cnt  <= last ? 4'd0 : cnt + 4'd1;
            tcnt <= '0;
         end else if (cnt == 4'd0) begin
            tcnt <= '0;
         end else if (tcnt == TW'(TIMEOUT - 1)) begin
            // stalled partial frame: resynchronise on the next start bit
            cnt  <= 4'd0;
            tcnt <= '0;
         end else begin
            tcnt <= tcnt + TW'(1);
         end
      end
   end
   sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (rd_en),
      .din   (shift[8:1]),
      .head  (data_out),
      .full  (full),
      .empty (empty)
   );
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed self-checking bench for ps2_rx_fifo.
module tb_ps2_rx_fifo;
   localparam int TIMEOUT = 1000;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rd_en = 1'b0;
   logic [7:0] data_out;
   logic       valid, overflow, frame_err;
   int         passed = 0;
   int         total = 0;

   ps2_rx_fifo #(.FIFO_DEPTH(8), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .rd_en     (rd_en),
      .data_out  (data_out),
      .valid     (valid),
      .overflow  (overflow),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // one PS/2 bit; returns in the cycle where the DUT sees the falling edge
   task automatic ps2_bit(input logic b);
      repeat (4) tick();
      ps2_clk  = 1'b1;
      ps2_data = b;
      repeat (6) tick();
      ps2_clk = 1'b0;
      repeat (2) tick();
   endtask

   task automatic release_clk();
      repeat (4) tick();
      ps2_clk = 1'b1;
      repeat (4) tick();
   endtask

   // returns in the falling-edge cycle of the stop bit
   task automatic send_frame(input logic [7:0] b, input logic bad_par);
      logic [10:0] f;
      f = {1'b1, ~^b ^ bad_par, b, 1'b0};
      for (int i = 0; i < 11; i++) ps2_bit(f[i]);
   endtask

   task automatic send_good(input logic [7:0] b);
      send_frame(b, 1'b0);
      tick();
      release_clk();
   endtask

   task automatic pop();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      repeat (3) tick();
      rst = 1'b1;
      chk("rst_valid", {7'd0, valid}, 8'd0);
      chk("rst_data", data_out, 8'h00);
      chk("rst_ovf", {7'd0, overflow}, 8'd0);
      chk("rst_ferr", {7'd0, frame_err}, 8'd0);

      send_frame(8'h1C, 1'b0);
      chk("1c_valid_e", {7'd0, valid}, 8'd0);
      tick();
      chk("1c_valid", {7'd0, valid}, 8'd1);
      chk("1c_data", data_out, 8'h1C);
      chk("1c_ferr", {7'd0, frame_err}, 8'd0);
      release_clk();
      pop();
      chk("1c_pop_valid", {7'd0, valid}, 8'd0);
      chk("1c_pop_data", data_out, 8'h00);
      pop();
      chk("empty_pop_valid", {7'd0, valid}, 8'd0);

      send_frame(8'h1C, 1'b1);
      chk("bad_ferr_e", {7'd0, frame_err}, 8'd0);
      tick();
      chk("bad_ferr", {7'd0, frame_err}, 8'd1);
      chk("bad_valid", {7'd0, valid}, 8'd0);
      tick();
      chk("bad_ferr_clr", {7'd0, frame_err}, 8'd0);
      release_clk();
      send_good(8'hF0);
      chk("f0_data", data_out, 8'hF0);
      chk("f0_valid", {7'd0, valid}, 8'd1);
      pop();

      for (int i = 1; i <= 8; i++) send_good(8'(i));
      chk("fill_ovf", {7'd0, overflow}, 8'd0);
      send_good(8'h09);
      chk("drop_ovf", {7'd0, overflow}, 8'd1);
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("drain_%0d", i), data_out, 8'(i));
         pop();
      end
      chk("drain_valid", {7'd0, valid}, 8'd0);
      chk("drain_ovf", {7'd0, overflow}, 8'd1);

      for (int i = 0; i < 6; i++) ps2_bit(i[0]);
      release_clk();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("mid_rst_valid", {7'd0, valid}, 8'd0);
      chk("mid_rst_ovf", {7'd0, overflow}, 8'd0);
      chk("mid_rst_ferr", {7'd0, frame_err}, 8'd0);
      send_good(8'h33);
      chk("33_data", data_out, 8'h33);
      pop();
      chk("33_only", {7'd0, valid}, 8'd0);

      for (int i = 1; i <= 8; i++) send_good(8'(i));
      send_frame(8'h09, 1'b0);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("fullpop_ovf", {7'd0, overflow}, 8'd0);
      chk("fullpop_head", data_out, 8'h02);
      release_clk();
      for (int i = 2; i <= 9; i++) begin
         chk($sformatf("fullpop_%0d", i), data_out, 8'(i));
         pop();
      end
      chk("fullpop_valid", {7'd0, valid}, 8'd0);
      chk("fullpop_ovf2", {7'd0, overflow}, 8'd0);

      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b1);
      release_clk();
      repeat (TIMEOUT + 10) tick();
      send_frame(8'h5A, 1'b0);
      tick();
      chk("to_ferr", {7'd0, frame_err}, 8'd0);
      chk("to_valid", {7'd0, valid}, 8'd1);
      chk("to_data", data_out, 8'h5A);
      release_clk();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Upstream serial front end for the shift-register / keyboard datapath.
- Synchronises an external PS/2 clock/data pair and deframes 11-bit PS/2 frames.
- Buffers valid bytes in a small FIFO with a show-ahead read interface.
- Downstream stages pop bytes at their own rate and load them (ctrl=load) or replay them bitwise.

Parameters:
- FIFO_DEPTH, 8, number of byte entries; must be a power of two, 2..64.
- TIMEOUT, 1000, idle clk cycles within a partial frame before the bit counter is discarded.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- ps2_clk  in  1  asynchronous PS/2 clock from the device.
- ps2_data  in  1  asynchronous PS/2 data from the device.
- rd_en  in  1  consumer pop request; honoured only while valid=1.
- data_out  out  8  FIFO head byte (show-ahead).
- valid  out  1  FIFO non-empty.
- overflow  out  1  sticky: a good frame was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse: completed frame failed the start/stop/parity check.

Behaviour:
- Reset (rst=0 at a clk edge):
  - Clears the synchroniser chains to all ones, the bit counter, the shift buffer, both FIFO pointers, the timeout counter, overflow and frame_err.
  - Outputs after reset: valid=0, data_out=0x00, overflow=0, frame_err=0.
  - Reset mid-frame discards the partial frame.
- Synchronisers:
  - ps2_clk passes through a 3-flop chain s[2:0].
  - Falling edge E is asserted when s[2]=1 and s[1]=0.
  - ps2_data passes through a 2-flop chain; its synchronised value is sampled on E.
- Frame format (11 bits, in this order): start=0, d0..d7 (LSB first), odd parity, stop=1.
- Bit counter:
  - Counts 0..10.
  - Each E stores the sampled bit at index cnt, then increments cnt.
  - At cnt=10 the frame completes and cnt returns to 0.
- Frame check, performed in the same cycle as the 10th-index E:
  - Good frame requires start=0, stop=1, and XOR(d7..d0, parity)=1.
  - Good frame: push d[7:0]. valid is seen at E+1.
  - Bad frame: frame_err=1 for exactly the cycle E+1; nothing is pushed.
- Timeout:
  - Counter is cleared on every E and while cnt=0.
  - Increments each cycle while cnt≠0 and there is no E.
  - On reaching TIMEOUT, cnt is reset to 0 and the timeout counter clears.
  - No frame_err is raised on timeout.
- FIFO:
  - Read and write pointers are $clog2(FIFO_DEPTH)+1 bits; they wrap naturally.
  - Empty when the pointers are equal; full when the MSBs differ and the remaining bits are equal.
  - data_out = mem[rptr] combinationally; data_out=0x00 when empty.
- Pop:
  - rd_en=1 with valid=1 advances rptr at the clk edge.
  - rd_en while empty is ignored (no pointer change, no error).
- Push when full:
  - Without a simultaneous pop: the byte is dropped and overflow is set to 1. overflow stays 1 until reset.
  - With a simultaneous pop in the same cycle: the push is accepted, the occupancy stays FIFO_DEPTH, and overflow is unchanged.
- Simultaneous push and pop with the FIFO non-empty: both occur and occupancy is unchanged.
- Push with the FIFO empty: valid rises at E+1.
- Assumption on input rate: the ps2_clk half-period is far longer than 3 clk cycles. A glitch shorter than 2 clk cycles may produce at most one spurious E, which the parity/stop check then catches.

Decomposition:
- Shared package ps2_pkg holds:
  - localparam PS2_FRAME_BITS=11.
  - Index constants PS2_START_IDX=0, PS2_PARITY_IDX=9, PS2_STOP_IDX=10.
  - A function odd_parity_ok(data, parity).
- One natural sub-module: sync_fifo (byte-wide, FIFO_DEPTH parameter, push/pop/full/empty/head outputs). It is reused by other receive paths in the design.
- Deframer, synchroniser and timeout logic stay in ps2_rx_fifo.

Test Plan:
- Send frame for 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1), then hold rd_en=0 → valid=1 one cycle after the 11th falling edge, data_out=0x1C. Then pulse rd_en for one cycle → valid=0, data_out=0x00.
- Send 0x1C with parity=1 → frame_err high for exactly 1 clk, valid stays 0, FIFO empty. Next a good frame 0xF0 (parity 1) → data_out=0xF0.
- Send 9 good frames 0x01..0x09 with no reads → after the 9th frame overflow=1. Reading 8 times yields 0x01..0x08 in order, then valid=0. overflow remains 1 until rst=0.
- With the FIFO full, send a 9th frame while rd_en=1 in the push cycle → 0x01 is popped, 0x09 is accepted, overflow stays 0, and the subsequent reads return 0x02..0x09.
- Clock in 5 bits, then idle for TIMEOUT+10 cycles, then send a full 0x5A frame (parity 1) → data_out=0x5A, no frame_err.
- Assert rst=0 for one cycle after 6 bits of a frame, then send 0x33 (parity 1) → only 0x33 is received, and valid/overflow/frame_err are all 0 in the cycle after reset.
